tone_seq: RTL and testbench



---
 rtl/tone_seq.sv | 165 ++++++++++++++++
 tb/tb_tone_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_seq.sv
// Multi-channel programmable tone sequencer on a word-addressed register bus.
// Each channel drives a square wave at a chromatic note/octave, optionally for a timed duration.
module tone_seq #(
    parameter int CHANNELS = 2,
    parameter int TICK_DIV = 62500,
    parameter int DUR_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cs,
    input  logic                we,
    input  logic [3:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [CHANNELS-1:0] buzz,
    output logic                buzz_mix,
    output logic                irq
);

    localparam int PH_W = 15;
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [3:0] STATUS_ADDR = 4'(2 * CHANNELS);

    function automatic logic [13:0] base_half(input logic [3:0] n);
        case (n)
            4'd1:    base_half = 14'd14931;
            4'd2:    base_half = 14'd14093;
            4'd3:    base_half = 14'd13302;
            4'd4:    base_half = 14'd12555;
            4'd5:    base_half = 14'd11850;
            4'd6:    base_half = 14'd11185;
            4'd7:    base_half = 14'd10558;
            4'd8:    base_half = 14'd9965;
            4'd9:    base_half = 14'd9406;
            4'd10:   base_half = 14'd8878;
            4'd11:   base_half = 14'd8380;
            4'd12:   base_half = 14'd7909;
            4'd13:   base_half = 14'd7465;
            default: base_half = 14'd0;
        endcase
    endfunction

    logic [CHANNELS-1:0] done_vec;
    logic [31:0]         ctrl_word [CHANNELS];
    logic [31:0]         dur_word  [CHANNELS];
    logic                wr_status;
    logic                unused_wdata;

    assign wr_status    = cs && we && (addr == STATUS_ADDR);
    assign unused_wdata = ^wdata;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [3:0]      note_reg, note_next;
            logic [1:0]      octave_reg, octave_next;
            logic [DUR_W-1:0] dur_reg, dur_next;
            logic [DUR_W-1:0] remain_reg, remain_next;
            logic            active_reg, active_next;
            logic            done_reg, done_next;
            logic [PH_W-1:0] phase_reg, phase_next;
            logic [PS_W-1:0] presc_reg, presc_next;
            logic [13:0]     half;
            logic [PH_W-1:0] period_last;
            logic            ctrl_wr, dur_wr, note_valid, expire;

            assign ctrl_wr     = cs && we && (addr == 4'(2 * gi));
            assign dur_wr      = cs && we && (addr == 4'(2 * gi + 1));
            assign note_valid  = (wdata[3:0] >= 4'd1) && (wdata[3:0] <= 4'd13);
            assign half        = base_half(note_reg) >> octave_reg;
            assign period_last = {half, 1'b0} - PH_W'(1);
            // Remaining count of zero means continuous, so only a count of one can expire.
            assign expire      = active_reg && (remain_reg == DUR_W'(1)) && (presc_reg == PS_LAST);

            always_comb begin
                note_next   = note_reg;
                octave_next = octave_reg;
                dur_next    = dur_reg;
                remain_next = remain_reg;
                active_next = active_reg;
                done_next   = done_reg;
                phase_next  = phase_reg;
                presc_next  = presc_reg;
                if (active_reg) begin
                    phase_next = (phase_reg == period_last) ? '0 : phase_reg + PH_W'(1);
                    if (remain_reg != '0) begin
                        if (presc_reg == PS_LAST) begin
                            presc_next  = '0;
                            remain_next = remain_reg - DUR_W'(1);
                            if (remain_reg == DUR_W'(1))
                                active_next = 1'b0;
                        end else begin
                            presc_next = presc_reg + PS_W'(1);
                        end
                    end
                end
                if (dur_wr)
                    dur_next = wdata[DUR_W-1:0];
                if (wr_status && wdata[gi])
                    done_next = 1'b0;
                // A CTRL write overrides a same-cycle expiry; an expiry overrides a same-cycle clear.
                if (ctrl_wr) begin
                    note_next   = wdata[3:0];
                    octave_next = wdata[5:4];
                    if (note_valid) begin
                        active_next = 1'b1;
                        phase_next  = '0;
                        presc_next  = '0;
                        remain_next = dur_reg;
                    end else begin
                        active_next = 1'b0;
                    end
                end else if (expire) begin
                    done_next = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    note_reg   <= '0;
                    octave_reg <= '0;
                    dur_reg    <= '0;
                    remain_reg <= '0;
                    active_reg <= 1'b0;
                    done_reg   <= 1'b0;
                    phase_reg  <= '0;
                    presc_reg  <= '0;
                end else begin
                    note_reg   <= note_next;
                    octave_reg <= octave_next;
                    dur_reg    <= dur_next;
                    remain_reg <= remain_next;
                    active_reg <= active_next;
                    done_reg   <= done_next;
                    phase_reg  <= phase_next;
                    presc_reg  <= presc_next;
                end
            end

            assign buzz[gi]      = active_reg && ({1'b0, half} > phase_reg);
            assign done_vec[gi]  = done_reg;
            assign ctrl_word[gi] = {25'b0, active_reg, octave_reg, note_reg};
            assign dur_word[gi]  = 32'(dur_reg);
        end
    endgenerate

    assign buzz_mix = |buzz;
    assign irq      = |done_vec;

    always_comb begin
        rdata = '0;
        if (cs) begin
            if (addr == STATUS_ADDR)
                rdata = 32'(done_vec);
            for (int c = 0; c < CHANNELS; c++) begin
                if (addr == 4'(2 * c))
                    rdata = ctrl_word[c];
                if (addr == 4'(2 * c + 1))
                    rdata = dur_word[c];
            end
        end
    end

endmodule

// File: tb/tb_tone_seq.sv
// Bench for tone_seq: timestamp-based channel model checked every cycle, plus literal spot checks.
module tb_tone_seq;

    localparam int CH = 2;
    localparam int TD = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [CH-1:0] buzz;
    logic        buzz_mix;
    logic        irq;

    tone_seq #(.CHANNELS(CH), .TICK_DIV(TD), .DUR_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .buzz(buzz), .buzz_mix(buzz_mix), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    int btab [14] = '{0, 14931, 14093, 13302, 12555, 11850, 11185, 10558, 9965,
                      9406, 8878, 8380, 7909, 7465};

    // Model state: a playing note is a start timestamp, half period and optional end timestamp.
    int m_start [CH];
    int m_h     [CH];
    int m_end   [CH];
    bit m_act   [CH];
    bit m_timed [CH];
    bit m_done  [CH];
    int m_note  [CH];
    int m_oct   [CH];
    int m_dur   [CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_buzz(input int c);
        if (!m_act[c]) return 1'b0;
        return ((cyc - m_start[c]) % (2 * m_h[c])) < m_h[c];
    endfunction

    function automatic logic [31:0] m_rd(input int a);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            if (a == 2 * c) v = 32'((int'(m_act[c]) << 6) | (m_oct[c] << 4) | m_note[c]);
            if (a == 2 * c + 1) v = 32'(m_dur[c]);
            if (m_done[c] && a == 2 * CH) v[c] = 1'b1;
        end
        return v;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int c = 0; c < CH; c++) begin
            bit set_done;
            if (!reset_n) begin
                m_act[c] = 0; m_timed[c] = 0; m_done[c] = 0;
                m_note[c] = 0; m_oct[c] = 0; m_dur[c] = 0;
                m_start[c] = 0; m_h[c] = 1; m_end[c] = 0;
            end else begin
                set_done = m_act[c] && m_timed[c] && (cyc == m_end[c]);
                if (set_done) m_act[c] = 0;
                if (cs && we && addr == 4'(2 * c)) begin
                    set_done  = 0;
                    m_note[c] = int'(wdata[3:0]);
                    m_oct[c]  = int'(wdata[5:4]);
                    if (m_note[c] >= 1 && m_note[c] <= 13) begin
                        m_act[c]   = 1;
                        m_start[c] = cyc;
                        m_h[c]     = btab[m_note[c]] >> m_oct[c];
                        m_timed[c] = (m_dur[c] != 0);
                        m_end[c]   = cyc + m_dur[c] * TD;
                    end else begin
                        m_act[c] = 0;
                    end
                end
                if (cs && we && addr == 4'(2 * c + 1)) m_dur[c] = int'(wdata[15:0]);
                if (cs && we && addr == 4'(2 * CH) && wdata[c]) m_done[c] = 0;
                if (set_done) m_done[c] = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit mix, anyd;
            mix = 0; anyd = 0;
            for (int c = 0; c < CH; c++) begin
                chk($sformatf("buzz%0d", c), 32'(buzz[c]), 32'(m_buzz(c)));
                mix  = mix | m_buzz(c);
                anyd = anyd | m_done[c];
            end
            chk("buzz_mix", 32'(buzz_mix), 32'(mix));
            chk("irq", 32'(irq), 32'(anyd));
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1; we = 1; addr = a; wdata = d;
        @(negedge clk);
        cs = 0; we = 0;
    endtask

    task automatic wr_at(input int t, input logic [3:0] a, input logic [31:0] d);
        while (cyc < t - 1) @(negedge clk);
        cs = 1; we = 1; addr = a; wdata = d;
        @(negedge clk);
        cs = 0; we = 0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
        cs = 1; we = 0; addr = a;
        #1;
        chk(name, rdata, exp);
        cs = 0;
    endtask

    task automatic rd_m(input logic [3:0] a, input string name);
        cs = 1; we = 0; addr = a;
        #1;
        chk(name, rdata, m_rd(int'(a)));
        cs = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k1;
        // Reset held for three edges while the bus tries to write.
        repeat (3) begin
            @(negedge clk);
            cs = ~cs; we = 1; addr = 4'd0; wdata = 32'h0A;
        end
        @(negedge clk);
        reset_n = 1; cs = 0; we = 0;
        chk_en = 1;
        #1;
        chk("rst_buzz", 32'(buzz), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        for (int a = 0; a <= 4; a++) rd(4'(a), 32'h0, $sformatf("rst_reg%0d", a));
        cs = 0; addr = 4'd0; #1;
        chk("cs0_rdata", rdata, 32'h0);

        // Continuous tones on both channels.
        wr(4'd1, 32'h0);
        wr(4'd0, 32'h0A); k = cyc;
        wr(4'd2, 32'h2A); k1 = cyc;
        rd(4'd0, 32'h4A, "ctrl0_rd");
        rd(4'd2, 32'h6A, "ctrl1_rd");
        wait_cyc(k1 + 2218); chk("ch1_hi_end", 32'(buzz[1]), 32'h1);
        wait_cyc(k1 + 2219); chk("ch1_fall", 32'(buzz[1]), 32'h0);
        wait_cyc(k1 + 4438); chk("ch1_rise", 32'(buzz[1]), 32'h1);
        wait_cyc(k + 8877);  chk("ch0_hi_end", 32'(buzz[0]), 32'h1);
        wait_cyc(k + 8878);  chk("ch0_fall", 32'(buzz[0]), 32'h0);
        wait_cyc(k + 17756); chk("ch0_rise", 32'(buzz[0]), 32'h1);
        wait_cyc(k + 3 * 17756 + 5); chk("cont_irq", 32'(irq), 32'h0);
        wr(4'd0, 32'h0);
        wr(4'd2, 32'h0);
        wr(4'd3, 32'h1234);
        rd_m(4'd3, "dur1_rd");

        // Timed note: 3 ticks of 10 clocks.
        wr(4'd1, 32'd3);
        wr(4'd0, 32'h01); k = cyc;
        wait_cyc(k + 29); chk("timed_hi", 32'(buzz[0]), 32'h1);
        chk("timed_irq_pre", 32'(irq), 32'h0);
        wait_cyc(k + 30); chk("timed_lo", 32'(buzz[0]), 32'h0);
        chk("timed_irq", 32'(irq), 32'h1);
        rd(4'd4, 32'h1, "status_done");
        wr(4'd4, 32'h2); chk("clr_other", 32'(irq), 32'h1);
        wr(4'd4, 32'h1); chk("clr_own", 32'(irq), 32'h0);

        // Restart on the expiry edge: no done, new continuous note.
        wr(4'd1, 32'd3);
        wr(4'd0, 32'h01); k = cyc;
        wr(4'd1, 32'd0);
        wr_at(k + 30, 4'd0, 32'h05);
        rd(4'd4, 32'h0, "restart_nodone");
        rd(4'd0, 32'h45, "restart_ctrl");
        wait_cyc(k + 30 + 11849); chk("restart_hi", 32'(buzz[0]), 32'h1);
        wait_cyc(k + 30 + 11850); chk("restart_fall", 32'(buzz[0]), 32'h0);

        // Clear on the done-set edge: set wins.
        wr(4'd1, 32'd3);
        wr(4'd0, 32'h01); k = cyc;
        wr_at(k + 30, 4'd4, 32'h1);
        rd(4'd4, 32'h1, "setwins_status");
        chk("setwins_irq", 32'(irq), 32'h1);
        wr(4'd4, 32'h1);

        // Stop mid high phase.
        wr(4'd1, 32'd0);
        wr(4'd0, 32'h0A); k = cyc;
        wait_cyc(k + 100); chk("stop_pre", 32'(buzz[0]), 32'h1);
        wr(4'd0, 32'h00);
        chk("stop_buzz", 32'(buzz[0]), 32'h0);
        rd(4'd4, 32'h0, "stop_nodone");

        // Reset during a timed note.
        wr(4'd1, 32'd5);
        wr(4'd0, 32'h01); k = cyc;
        wait_cyc(k + 20);
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        wait_cyc(k + 60);
        chk("rstmid_irq", 32'(irq), 32'h0);
        rd(4'd4, 32'h0, "rstmid_status");
        rd(4'd0, 32'h0, "rstmid_ctrl");
        rd(4'd1, 32'h0, "rstmid_dur");

        rd(4'd15, 32'h0, "unmapped_f");
        rd(4'd5, 32'h0, "unmapped_5");
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
